// File: rtl/car_sprite_engine.sv
// Car sprite draw/erase responder: walks a SPRITE_W x SPRITE_H rectangle at the latched car
// position, two cycles per pixel, plotting sprite colours (draw) or background colours (erase).
//
// state   | meaning
// IDLE    | waiting for draw_en (priority) or erase_en
// ADDR    | ROM addresses for the current pixel are presented
// PLOT    | ROM data is back; pixel written unless clipped or transparent
// DONE    | one-cycle done pulse for the served mode
// RELEASE | wait for the served enable to drop
module car_sprite_engine #(
    parameter int         SPRITE_W    = 8,
    parameter int         SPRITE_H    = 8,
    parameter int         SPR_AW      = 6,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              draw_en,
    input  logic              erase_en,
    input  logic              ldXY,
    input  logic [7:0]        car_x,
    input  logic [6:0]        car_y,
    output logic [SPR_AW-1:0] spr_addr,
    input  logic [2:0]        spr_data,
    output logic [14:0]       bg_addr,
    input  logic [2:0]        bg_data,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              draw_done,
    output logic              erase_done
);

    localparam int IW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int JW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PLOT,
        S_DONE,
        S_RELEASE
    } state_t;

    typedef enum logic {
        M_DRAW,
        M_ERASE
    } mode_t;

    state_t        state;
    mode_t         mode;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [7:0]    pos_x;
    logic [6:0]    pos_y;
    logic [8:0]    px_q;
    logic [7:0]    py_q;
    logic [2:0]    colour_q;

    logic              last_col;
    logic              last_row;
    logic [IW-1:0]     i_nxt;
    logic [JW-1:0]     j_nxt;
    logic [7:0]        base_x;
    logic [6:0]        base_y;
    logic [8:0]        px_nxt;
    logic [7:0]        py_nxt;
    logic [SPR_AW-1:0] spr_nxt;
    logic [14:0]       bg_nxt;
    logic              in_screen;
    logic [2:0]        pix_colour;

    assign last_col = (i == IW'(SPRITE_W - 1));
    assign last_row = (j == JW'(SPRITE_H - 1));

    // Next pixel coordinates, shared by the IDLE->ADDR and PLOT->ADDR transitions so that
    // the addresses are already registered for the whole ADDR cycle.
    always_comb begin
        i_nxt  = i;
        j_nxt  = j;
        base_x = pos_x;
        base_y = pos_y;
        if (state == S_IDLE) begin
            i_nxt = '0;
            j_nxt = '0;
            if (draw_en && ldXY) begin
                base_x = car_x;
                base_y = car_y;
            end
        end else if (last_col) begin
            i_nxt = '0;
            j_nxt = j + JW'(1);
        end else begin
            i_nxt = i + IW'(1);
        end
    end

    assign px_nxt  = {1'b0, base_x} + 9'(i_nxt);
    assign py_nxt  = {1'b0, base_y} + 8'(j_nxt);
    assign spr_nxt = SPR_AW'(j_nxt) * SPR_AW'(SPRITE_W) + SPR_AW'(i_nxt);
    assign bg_nxt  = 15'(py_nxt) * 15'(SCREEN_W) + 15'(px_nxt);

    assign in_screen  = (px_q < 9'(SCREEN_W)) && (py_q < 8'(SCREEN_H));
    assign pix_colour = (mode == M_DRAW) ? spr_data : bg_data;

    // ROM data only arrives during PLOT, so the strobe and colour are decoded from it directly.
    assign vga_plot   = (state == S_PLOT) && in_screen &&
                        ((mode == M_ERASE) || (spr_data != TRANSPARENT));
    assign vga_colour = (state == S_PLOT) ? pix_colour : colour_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            mode       <= M_DRAW;
            i          <= '0;
            j          <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
            px_q       <= '0;
            py_q       <= '0;
            spr_addr   <= '0;
            bg_addr    <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            colour_q   <= '0;
            draw_done  <= 1'b0;
            erase_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (draw_en) begin
                        mode <= M_DRAW;
                        if (ldXY) begin
                            pos_x <= car_x;
                            pos_y <= car_y;
                        end
                    end else if (erase_en) begin
                        mode <= M_ERASE;
                    end
                    if (draw_en || erase_en) begin
                        i        <= i_nxt;
                        j        <= j_nxt;
                        px_q     <= px_nxt;
                        py_q     <= py_nxt;
                        spr_addr <= spr_nxt;
                        bg_addr  <= bg_nxt;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    vga_x <= px_q[7:0];
                    vga_y <= py_q[6:0];
                    state <= S_PLOT;
                end
                S_PLOT: begin
                    colour_q <= pix_colour;
                    i        <= i_nxt;
                    j        <= j_nxt;
                    if (last_col && last_row) begin
                        if (mode == M_DRAW) draw_done <= 1'b1;
                        else                erase_done <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        px_q     <= px_nxt;
                        py_q     <= py_nxt;
                        spr_addr <= spr_nxt;
                        bg_addr  <= bg_nxt;
                        state    <= S_ADDR;
                    end
                end
                S_DONE: begin
                    draw_done  <= 1'b0;
                    erase_done <= 1'b0;
                    state      <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Only the served enable matters; the other may already be waiting in IDLE.
                    if ((mode == M_DRAW && !draw_en) || (mode == M_ERASE && !erase_en))
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_car_sprite_engine.sv
// Directed bench for car_sprite_engine: table of draw/erase requests checked against a
// pixel-list model, plus hand sequences for mid-op enable drop, erase->draw handoff and reset.
module tb_car_sprite_engine;

    logic        clk = 1'b0;
    logic        resetn;
    logic        draw_en, erase_en, ldXY;
    logic [7:0]  car_x;
    logic [6:0]  car_y;
    logic [5:0]  spr_addr;
    logic [2:0]  spr_data;
    logic [14:0] bg_addr;
    logic [2:0]  bg_data;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, draw_done, erase_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] spr_rom [0:63];

    car_sprite_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .draw_en    (draw_en),
        .erase_en   (erase_en),
        .ldXY       (ldXY),
        .car_x      (car_x),
        .car_y      (car_y),
        .spr_addr   (spr_addr),
        .spr_data   (spr_data),
        .bg_addr    (bg_addr),
        .bg_data    (bg_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .draw_done  (draw_done),
        .erase_done (erase_done)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] bgf(input logic [14:0] a);
        return a[2:0] ^ a[7:5] ^ a[12:10];
    endfunction

    // Synchronous ROMs: data valid one cycle after the address.
    always @(posedge clk) begin
        spr_data <= spr_rom[spr_addr];
        bg_data  <= bgf(bg_addr);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // pattern 0: solid 3'b100; pattern 1: transparent at odd columns, 3'b110 elsewhere
    task automatic load_pat(input int p);
        for (int k = 0; k < 64; k++) begin
            if (p == 0)          spr_rom[k] = 3'b100;
            else if (k % 2 == 1) spr_rom[k] = 3'b000;
            else                 spr_rom[k] = 3'b110;
        end
    endtask

    typedef struct {
        bit         draw;
        bit         erase;
        bit         ldxy;
        logic [7:0] cx;
        logic [6:0] cy;
        int         pat;
        int         ex;
        int         ey;
        int         exp_cnt;
        bit         exp_draw;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    // Must be called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_op(input string name, input vec_t v);
        pix_t exp_q[$];
        pix_t e;
        int nplot, bad, first, done_cyc, other, sx, sy, sc;
        exp_q.delete();
        load_pat(v.pat);
        for (int jj = 0; jj < 8; jj++)
            for (int ii = 0; ii < 8; ii++) begin
                sx = v.ex + ii;
                sy = v.ey + jj;
                sc = v.exp_draw ? int'(spr_rom[jj*8+ii]) : int'(bgf(15'(sy*160 + sx)));
                if (sx < 160 && sy < 120 && (!v.exp_draw || sc != 0)) begin
                    e.x = sx; e.y = sy; e.c = sc;
                    exp_q.push_back(e);
                end
            end
        draw_en = v.draw; erase_en = v.erase; ldXY = v.ldxy; car_x = v.cx; car_y = v.cy;
        nplot = 0; bad = 0; first = -1; done_cyc = -1; other = 0;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (vga_plot) begin
                if (first < 0) first = c;
                if (nplot >= exp_q.size()) bad++;
                else if (int'(vga_x) != exp_q[nplot].x || int'(vga_y) != exp_q[nplot].y ||
                         int'(vga_colour) != exp_q[nplot].c) bad++;
                nplot++;
            end
            if (v.exp_draw ? draw_done : erase_done) done_cyc = c;
            if (v.exp_draw ? erase_done : draw_done) other++;
        end
        ldXY = 1'b0;
        if (v.exp_draw) draw_en = 1'b0;
        else            erase_en = 1'b0;
        check({name, " plot count"}, nplot, v.exp_cnt);
        check({name, " pixel mismatches"}, bad, 0);
        check({name, " first plot cycle"}, first, 2);
        check({name, " done cycle"}, done_cyc, 129);
        check({name, " other done pulses"}, other, 0);
        @(negedge clk);
        check({name, " done width"}, int'(draw_done | erase_done | vga_plot), 0);
        @(negedge clk);
    endtask

    vec_t vecs [9];

    initial begin
        int nplot, done_cyc, n_ed, n_dd;
        bit swapped;

        vecs[0] = '{1, 0, 1, 8'd10,  7'd20,  0, 10,  20,  64, 1};
        vecs[1] = '{0, 1, 0, 8'd0,   7'd0,   0, 10,  20,  64, 0};
        vecs[2] = '{1, 0, 1, 8'd40,  7'd30,  1, 40,  30,  32, 1};
        vecs[3] = '{1, 0, 1, 8'd156, 7'd116, 0, 156, 116, 16, 1};
        vecs[4] = '{0, 1, 1, 8'd50,  7'd5,   0, 156, 116, 16, 0};
        vecs[5] = '{1, 1, 1, 8'd100, 7'd50,  0, 100, 50,  64, 1};
        vecs[6] = '{0, 1, 0, 8'd0,   7'd0,   0, 100, 50,  64, 0};
        vecs[7] = '{1, 0, 0, 8'd0,   7'd0,   1, 100, 50,  32, 1};
        vecs[8] = '{1, 0, 1, 8'd159, 7'd0,   0, 159, 0,   8,  1};

        resetn = 1'b0; draw_en = 1'b0; erase_en = 1'b0; ldXY = 1'b0; car_x = '0; car_y = '0;
        load_pat(0);
        repeat (3) @(negedge clk);
        check("reset plot/done", int'({vga_plot, draw_done, erase_done}), 0);
        check("reset addresses", int'({spr_addr, bg_addr}), 0);
        check("reset pixel regs", int'({vga_x, vga_y, vga_colour}), 0);
        resetn = 1'b1;

        for (int k = 0; k < 9; k++) run_op($sformatf("vec%0d", k), vecs[k]);

        // Draw enable dropped mid-operation still completes with a done pulse.
        load_pat(0);
        draw_en = 1'b1; ldXY = 1'b1; car_x = 8'd20; car_y = 7'd20;
        nplot = 0; done_cyc = -1;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 5) begin draw_en = 1'b0; ldXY = 1'b0; end
            if (vga_plot) nplot++;
            if (draw_done) done_cyc = c;
        end
        check("drop plot count", nplot, 64);
        check("drop done cycle", done_cyc, 129);
        repeat (2) @(negedge clk);

        // Erase -> draw handoff: erase_en falls exactly as draw_en rises.
        erase_en = 1'b1;
        n_ed = 0; n_dd = 0; done_cyc = -1; swapped = 0;
        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (erase_done) begin
                n_ed++;
                if (!swapped) begin
                    erase_en = 1'b0; draw_en = 1'b1; ldXY = 1'b1;
                    car_x = 8'd60; car_y = 7'd60; swapped = 1;
                end
            end
            if (draw_done) begin
                n_dd++; done_cyc = c; draw_en = 1'b0; ldXY = 1'b0;
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (erase_done) n_ed++;
            if (draw_done) n_dd++;
        end
        check("handoff erase_done count", n_ed, 1);
        check("handoff draw_done count", n_dd, 1);
        check("handoff draw done cycle", done_cyc, 260);

        // Reset at the 30th plotted pixel of a draw.
        load_pat(0);
        draw_en = 1'b1; ldXY = 1'b1; car_x = 8'd10; car_y = 7'd20;
        nplot = 0;
        for (int c = 1; c <= 200 && nplot < 30; c++) begin
            @(negedge clk);
            if (vga_plot) nplot++;
        end
        check("plots before reset", nplot, 30);
        resetn = 1'b0; draw_en = 1'b0; ldXY = 1'b0;
        @(negedge clk);
        check("post-reset plot/done", int'({vga_plot, draw_done, erase_done}), 0);
        check("post-reset addresses", int'({spr_addr, bg_addr}), 0);
        resetn = 1'b1;
        run_op("restart", '{1, 0, 1, 8'd30, 7'd40, 0, 30, 40, 64, 1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/car_sprite_engine.md
Name: car_sprite_engine

Overview:
- Responder side of the car draw/erase handshake issued by the game animation controller.
- On `draw_en`, renders a SPRITE_W x SPRITE_H car sprite from the sprite ROM at the latched car position.
- On `erase_en`, repaints the same rectangle from the background map ROM.
- Drives the VGA adapter pixel-write port and returns a single-cycle `done` per request.

Parameters:
- SPRITE_W, 8, sprite width in pixels.
- SPRITE_H, 8, sprite height in pixels.
- SPR_AW, 6, sprite ROM address width; must satisfy 2^SPR_AW >= SPRITE_W*SPRITE_H.
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- TRANSPARENT, 3'b000, sprite colour that is never plotted.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- draw_en  in  1  level request: draw car; held high by the controller until `draw_done`.
- erase_en  in  1  level request: restore background; held high until `erase_done`.
- ldXY  in  1  latch `car_x`/`car_y` when a draw request is accepted.
- car_x  in  8  car top-left x.
- car_y  in  7  car top-left y.
- spr_addr  out  SPR_AW  sprite ROM address, row-major j*SPRITE_W+i.
- spr_data  in  3  sprite ROM colour; valid 1 cycle after `spr_addr`.
- bg_addr  out  15  map ROM address, (py*SCREEN_W)+px.
- bg_data  in  3  map ROM colour; valid 1 cycle after `bg_addr`.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write strobe.
- draw_done  out  1  one-cycle pulse when a draw completes.
- erase_done  out  1  one-cycle pulse when an erase completes.

Behaviour:
- Reset (synchronous, resetn=0 at a clk edge):
  - state=IDLE; i=j=0; pos_x=pos_y=0.
  - All outputs 0.
  - Reset mid-operation aborts immediately; no done pulse and no further `vga_plot`.
- States: IDLE, ADDR, PLOT, DONE, RELEASE. The mode register is DRAW or ERASE.
- IDLE:
  - `draw_en`=1: mode=DRAW; if `ldXY`=1, latch pos_x/pos_y from `car_x`/`car_y`; i=j=0; go to ADDR.
  - `draw_en` has priority when both enables are high.
  - Otherwise `erase_en`=1: mode=ERASE; position is not re-latched, so the erase uses the last drawn position; go to ADDR.
- ADDR (1 cycle):
  - spr_addr=j*SPRITE_W+i; px=pos_x+i, py=pos_y+j, computed 9-bit/8-bit with no wrap.
  - bg_addr=py*SCREEN_W+px. Go to PLOT.
- PLOT (1 cycle):
  - vga_x=px[7:0], vga_y=py[6:0].
  - vga_colour = spr_data (DRAW) or bg_data (ERASE).
  - vga_plot=1 only if px<SCREEN_W and py<SCREEN_H (clip), and, in DRAW mode, spr_data!=TRANSPARENT.
  - Advance: i++; on i==SPRITE_W-1 wrap i=0 and j++.
  - After the last pixel (i==SPRITE_W-1, j==SPRITE_H-1) go to DONE; else go to ADDR.
- Timing:
  - Exactly 2 cycles per pixel.
  - 8x8 sprite: 128 cycles from leaving IDLE to entering DONE.
  - The first `vga_plot` occurs 2 cycles after the request is seen in IDLE.
- DONE (1 cycle): draw_done=1 if mode=DRAW, else erase_done=1. Go to RELEASE.
- RELEASE:
  - Wait until the enable of the served mode is 0, then go to IDLE.
  - The other enable may already be high; it is accepted on the IDLE cycle.
  - This supports an erase->draw handoff with no retrigger.
- Enable dropped mid-operation: the operation still completes and done still pulses.
- Outside PLOT, vga_plot=0; vga_x/vga_y/vga_colour hold their last values. Done signals are 0 outside DONE.

Test Plan:
- Reset, then draw_en=1, ldXY=1, car_x=10, car_y=20, sprite ROM all 3'b100 -> 64 plots covering x 10..17, y 20..27 in row-major order; first plot 2 cycles after acceptance; draw_done high exactly 1 cycle on cycle 129.
- Sprite checkerboard with TRANSPARENT at odd i -> exactly 32 plots; odd columns never written; draw_done still on cycle 129.
- Draw at (156,116), then erase_en with car_x changed to 50 -> erase plots only x 156..159, y 116..119 (16 pixels), with vga_colour=bg_data at bg_addr=y*160+x; erase_done pulses once.
- Erase completes, erase_en drops the same cycle draw_en rises -> exactly one draw begins; no second erase_done; draw_done appears once.
- draw_en and erase_en both high in IDLE -> DRAW served first; after release, ERASE runs if erase_en is still high.
- resetn=0 at pixel 30 of a draw -> vga_plot, draw_done and addresses all 0 next cycle; the FSM is idle, and a new draw_en restarts at i=j=0.
